common_dispatch_buffer4: RTL and testbench

- One-to-four stream dispatcher; mirror of the 4-to-1 cross buffer.
- Accepts a single valid/ready stream tagged with a 2-bit destination index and routes each beat into one of four independent 2-entry lane FIFOs.
- Each lane FIFO drives its own valid/ready output port.
- Sits upstream of per-lane consumers, such as the inputs of a 4-to-1 cross buffer, and decouples a stalled lane from the others except when the head beat targets that lane.

---
 rtl/common_dispatch_buffer4.sv | 129 ++++++++++++
 tb/tb_common_dispatch_buffer4.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/common_dispatch_buffer4.sv
// common_dispatch_buffer4: one-to-four stream dispatcher.
// A single tagged valid/ready stream is routed by prev_i_dst into one of four
// independent 2-entry lane FIFOs. Each lane drives its own valid/ready port.
// A beat whose lane is full stalls the input (head-of-line blocking by design).
// Lane outputs come straight from registers, so there is never a same-cycle
// bypass from input to output, and prev_o_ready never looks at downstream ready.
module common_dispatch_buffer4 #(
  parameter int BUFFER_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUFFER_WIDTH-1:0] prev_i_data,
  input  logic [1:0]              prev_i_dst,
  input  logic                    prev_i_valid,
  output logic                    prev_o_ready,
  output logic [BUFFER_WIDTH-1:0] next0_o_data,
  output logic                    next0_o_valid,
  input  logic                    next0_i_ready,
  output logic [BUFFER_WIDTH-1:0] next1_o_data,
  output logic                    next1_o_valid,
  input  logic                    next1_i_ready,
  output logic [BUFFER_WIDTH-1:0] next2_o_data,
  output logic                    next2_o_valid,
  input  logic                    next2_i_ready,
  output logic [BUFFER_WIDTH-1:0] next3_o_data,
  output logic                    next3_o_valid,
  input  logic                    next3_i_ready
);

  // Lane occupancy: the state encoding doubles as the entry count.
  typedef enum logic [1:0] {
    LANE_EMPTY = 2'd0,
    LANE_HALF  = 2'd1,
    LANE_FULL  = 2'd2
  } lane_state_t;

  logic [3:0]              lane_full;
  logic [3:0]              lane_valid;
  logic [3:0]              lane_ready;
  logic [BUFFER_WIDTH-1:0] lane_data [4];

  assign lane_ready = {next3_i_ready, next2_i_ready, next1_i_ready, next0_i_ready};

  // Acceptance depends only on the addressed lane's registered occupancy, so
  // a full lane refuses a beat even if it is popping in the same cycle.
  assign prev_o_ready = ~lane_full[prev_i_dst];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    lane_state_t             state_q;
    lane_state_t             state_d;
    logic [BUFFER_WIDTH-1:0] entry_q [2];
    logic                    wptr_q;
    logic                    rptr_q;
    logic                    push;
    logic                    pop;

    assign push = prev_i_valid & prev_o_ready & (prev_i_dst == 2'(k));
    assign pop  = lane_valid[k] & lane_ready[k];

    // Occupancy state register; reset empties the lane immediately.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= LANE_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    // Next occupancy: push alone grows, pop alone shrinks, both or neither hold.
    always_comb begin
      state_d = state_q;
      case (state_q)
        LANE_EMPTY: begin
          if (push) begin
            state_d = LANE_HALF;
          end
        end
        LANE_HALF: begin
          if (push && !pop) begin
            state_d = LANE_FULL;
          end else if (pop && !push) begin
            state_d = LANE_EMPTY;
          end
        end
        LANE_FULL: begin
          if (pop && !push) begin
            state_d = LANE_HALF;
          end
        end
        default: begin
          state_d = LANE_EMPTY;
        end
      endcase
    end

    // Storage and 1-bit wrapping pointers; storage is cleared on reset so no
    // stale payload can appear on the output after a reset.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        entry_q[0] <= '0;
        entry_q[1] <= '0;
        wptr_q     <= 1'b0;
        rptr_q     <= 1'b0;
      end else begin
        if (push) begin
          entry_q[wptr_q] <= prev_i_data;
          wptr_q          <= ~wptr_q;
        end
        if (pop) begin
          rptr_q <= ~rptr_q;
        end
      end
    end

    assign lane_full[k]  = (state_q == LANE_FULL);
    assign lane_valid[k] = (state_q != LANE_EMPTY);
    assign lane_data[k]  = entry_q[rptr_q];
  end

  assign next0_o_valid = lane_valid[0];
  assign next1_o_valid = lane_valid[1];
  assign next2_o_valid = lane_valid[2];
  assign next3_o_valid = lane_valid[3];
  assign next0_o_data  = lane_data[0];
  assign next1_o_data  = lane_data[1];
  assign next2_o_data  = lane_data[2];
  assign next3_o_data  = lane_data[3];

endmodule

// File: tb/tb_common_dispatch_buffer4.sv
// Self-checking bench for common_dispatch_buffer4: a queue-per-lane model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_common_dispatch_buffer4;

  logic        clk;
  logic        reset;
  logic [31:0] prev_i_data;
  logic [1:0]  prev_i_dst;
  logic        prev_i_valid;
  logic        prev_o_ready;
  logic [3:0]  rdy;
  logic [31:0] dut_data [4];
  logic [3:0]  dut_valid;

  int total;
  int bad;

  logic [31:0] model_q [4][$];
  logic [31:0] pop_log [4][$];

  common_dispatch_buffer4 #(.BUFFER_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .prev_i_data   (prev_i_data),
    .prev_i_dst    (prev_i_dst),
    .prev_i_valid  (prev_i_valid),
    .prev_o_ready  (prev_o_ready),
    .next0_o_data  (dut_data[0]),
    .next0_o_valid (dut_valid[0]),
    .next0_i_ready (rdy[0]),
    .next1_o_data  (dut_data[1]),
    .next1_o_valid (dut_valid[1]),
    .next1_i_ready (rdy[1]),
    .next2_o_data  (dut_data[2]),
    .next2_o_valid (dut_valid[2]),
    .next2_i_ready (rdy[2]),
    .next3_o_data  (dut_data[3]),
    .next3_o_valid (dut_valid[3]),
    .next3_i_ready (rdy[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, then let the rising edge consume them.
  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic [31:0] data,
                               input logic [3:0] r);
    @(negedge clk);
    #1;
    prev_i_valid = v;
    prev_i_dst   = d;
    prev_i_data  = data;
    rdy          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkLog(input int lane, input logic [31:0] exp0, input logic [31:0] exp1,
                          input logic [31:0] exp2, input int n);
    logic [31:0] e [3];
    e[0] = exp0;
    e[1] = exp1;
    e[2] = exp2;
    checkOutput($sformatf("log%0d_len", lane), 32'(pop_log[lane].size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < pop_log[lane].size()) begin
        checkOutput($sformatf("log%0d_%0d", lane, i), pop_log[lane][i], e[i]);
      end
    end
    pop_log[lane].delete();
  endtask

  // Model: each lane is a queue of at most two beats; accept iff addressed queue
  // is not full, pop iff queue non-empty and consumer ready. Also logs what
  // the DUT actually hands over on each lane.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        model_q[k].delete();
      end
    end else begin
      bit acc;
      bit [3:0] pops;
      for (int k = 0; k < 4; k++) begin
        if (dut_valid[k] && rdy[k]) begin
          pop_log[k].push_back(dut_data[k]);
        end
      end
      acc = prev_i_valid && (model_q[prev_i_dst].size() != 2);
      for (int k = 0; k < 4; k++) begin
        pops[k] = (model_q[k].size() != 0) && rdy[k];
      end
      for (int k = 0; k < 4; k++) begin
        if (pops[k]) begin
          void'(model_q[k].pop_front());
        end
      end
      if (acc) begin
        model_q[prev_i_dst].push_back(prev_i_data);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    checkOutput("ready", {31'd0, prev_o_ready}, {31'd0, model_q[prev_i_dst].size() != 2});
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("valid%0d", k), {31'd0, dut_valid[k]}, {31'd0, model_q[k].size() != 0});
      if (model_q[k].size() != 0) begin
        checkOutput($sformatf("data%0d", k), dut_data[k], model_q[k][0]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    prev_i_valid = 1'b0;
    prev_i_dst   = 2'd0;
    prev_i_data  = 32'd0;
    rdy          = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state.
    checkOutput("rst_ready", {31'd0, prev_o_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rst_valid%0d", k), {31'd0, dut_valid[k]}, 32'd0);
      checkOutput($sformatf("rst_data%0d", k), dut_data[k], 32'd0);
    end

    // Single beat to lane 2, one-cycle latency.
    $display("[TB] scenario 1");
    applyStimulus(1'b1, 2'd2, 32'hA0, 4'b0000);
    checkOutput("s1_valid2", {31'd0, dut_valid[2]}, 32'd1);
    checkOutput("s1_data2", dut_data[2], 32'hA0);
    checkOutput("s1_others", {28'd0, dut_valid[3], dut_valid[1:0]}, 32'd0);
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0100);
    checkLog(2, 32'hA0, 32'd0, 32'd0, 1);

    // Lane 1 fills, third beat stalls, one pop reopens it; order preserved.
    $display("[TB] scenario 2");
    applyStimulus(1'b1, 2'd1, 32'h11, 4'b0000);
    applyStimulus(1'b1, 2'd1, 32'h12, 4'b0000);
    applyStimulus(1'b1, 2'd1, 32'h13, 4'b0000);
    checkOutput("s2_full_ready", {31'd0, prev_o_ready}, 32'd0);
    checkOutput("s2_head", dut_data[1], 32'h11);
    applyStimulus(1'b1, 2'd1, 32'h13, 4'b0010);
    checkOutput("s2_reopen_ready", {31'd0, prev_o_ready}, 32'd1);
    checkOutput("s2_head_after_pop", dut_data[1], 32'h12);
    applyStimulus(1'b1, 2'd1, 32'h13, 4'b0000);
    repeat (3) applyStimulus(1'b0, 2'd0, 32'd0, 4'b0010);
    checkLog(1, 32'h11, 32'h12, 32'h13, 3);

    // Head-of-line blocking on full lane 3.
    $display("[TB] scenario 3");
    applyStimulus(1'b1, 2'd3, 32'h31, 4'b0000);
    applyStimulus(1'b1, 2'd3, 32'h32, 4'b0000);
    applyStimulus(1'b1, 2'd3, 32'h33, 4'b0000);
    applyStimulus(1'b1, 2'd3, 32'h33, 4'b0000);
    checkOutput("s3_hol_ready", {31'd0, prev_o_ready}, 32'd0);
    checkOutput("s3_others_empty", {29'd0, dut_valid[2:0]}, 32'd0);
    applyStimulus(1'b1, 2'd3, 32'h33, 4'b1000);
    applyStimulus(1'b1, 2'd3, 32'h33, 4'b0000);
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    checkOutput("s3_others_still_empty", {29'd0, dut_valid[2:0]}, 32'd0);
    repeat (3) applyStimulus(1'b0, 2'd0, 32'd0, 4'b1000);
    checkLog(3, 32'h31, 32'h32, 32'h33, 3);

    // Round-robin streaming with every consumer ready.
    $display("[TB] scenario 4");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 32'(i), 4'b1111);
      checkOutput($sformatf("s4_valid_%0d", i), {31'd0, dut_valid[i % 4]}, 32'd1);
      checkOutput($sformatf("s4_data_%0d", i), dut_data[i % 4], 32'(i));
    end
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      checkLog(k, 32'(k), 32'(k + 4), 32'd0, 2);
    end

    // Simultaneous push and pop on lane 0.
    $display("[TB] scenario 5");
    applyStimulus(1'b1, 2'd0, 32'h50, 4'b0000);
    applyStimulus(1'b1, 2'd0, 32'h51, 4'b0001);
    checkOutput("s5_head_51", dut_data[0], 32'h51);
    checkOutput("s5_valid", {31'd0, dut_valid[0]}, 32'd1);
    applyStimulus(1'b1, 2'd0, 32'h52, 4'b0000);
    checkOutput("s5_full_ready", {31'd0, prev_o_ready}, 32'd0);
    applyStimulus(1'b1, 2'd0, 32'h53, 4'b0001);
    checkOutput("s5_head_52", dut_data[0], 32'h52);
    checkOutput("s5_ready_back", {31'd0, prev_o_ready}, 32'd1);
    repeat (2) applyStimulus(1'b0, 2'd0, 32'd0, 4'b0001);
    checkLog(0, 32'h50, 32'h51, 32'h52, 3);

    // Asynchronous reset between edges discards everything.
    $display("[TB] scenario 6");
    applyStimulus(1'b1, 2'd0, 32'h61, 4'b0000);
    applyStimulus(1'b1, 2'd2, 32'h62, 4'b0000);
    applyStimulus(1'b0, 2'd0, 32'd0, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s6_async_valid", {28'd0, dut_valid}, 32'd0);
    checkOutput("s6_async_data0", dut_data[0], 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 2'd0, 32'h55, 4'b0000);
    checkOutput("s6_data0", dut_data[0], 32'h55);
    checkOutput("s6_valid2", {31'd0, dut_valid[2]}, 32'd0);
    repeat (2) applyStimulus(1'b0, 2'd0, 32'd0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      pop_log[k].delete();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
